// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and load/store requesters, the
// shared-memory arbiter and the single-ported memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            if_err;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            d_err;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  // Handshake: a requester holds *_req (and its fields) until the cycle in
  // which *_gnt is high; that cycle is the transfer. The arbiter holds mem_req
  // and the mem_* fields stable until the cycle mem_ack is high (or the
  // timeout fires). *_rvalid is a single-cycle pulse with no back-pressure.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic               state_dbg
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_d;
  logic          pick_d;
  logic          grant;
  logic          timeout_hit;

`ifdef MEM_ARB_RR_EN
  // last_d = 1 means D won the previous grant, so IF is favoured next.
  logic last_d;
  always_comb pick_d = bus.d_req && (!bus.if_req || !last_d);
`else
  always_comb pick_d = bus.d_req;
`endif

  always_comb begin
    grant       = (state == IDLE) && !rst && (bus.d_req || bus.if_req);
    bus.d_gnt   = grant && pick_d;
    bus.if_gnt  = grant && !pick_d;
    timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    state_dbg   = (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      owner_d       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_err    <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d        <= 1'b0;
`endif
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state       <= BUSY;
            cnt         <= '0;
            owner_d     <= pick_d;
            bus.mem_req <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_d      <= pick_d;
`endif
            if (pick_d) begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_be    <= bus.d_be;
            end else begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= '0;
              bus.mem_be    <= '1;
            end
          end
        end
        BUSY: begin
          // An ack in the timeout cycle still counts as success.
          if (bus.mem_ack || timeout_hit) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            if (owner_d) begin
              bus.d_rvalid <= 1'b1;
              bus.d_err    <= !bus.mem_ack;
              bus.d_rdata  <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_err    <= !bus.mem_ack;
              bus.if_rdata  <= bus.mem_ack ? bus.mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant, memory-request and response
// scoreboards fed by the stimulus and drained by independent monitors.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic clk;
  logic rst;
  logic state_dbg;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [0:0]  gnt_q[$];   // 1 = D, 0 = IF
  logic [68:0] mem_q[$];   // {we, addr, wdata, be}
  logic [65:0] rsp_q[$];   // {is_d, err, data, cycle}

  int          ack_lat  = 0;   // mem_req-high cycles before ack; <0 = never ack
  logic [31:0] mem_rval = 32'h0;
  int          last_run = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: checks request fields on the first mem_req cycle, acks after ack_lat
  initial begin : mem_model
    int mcnt;
    int cur_lat;
    logic [68:0] e;
    mcnt = 0;
    cur_lat = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0BAD0BAD;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (mcnt == 0) begin
          cur_lat = ack_lat;
          if (mem_q.size() == 0) begin
            check("mem_unexpected_req", 1, 0);
          end else begin
            e = mem_q.pop_front();
            check("mem_we", bus.mem_we, e[68]);
            check("mem_addr", bus.mem_addr, e[67:36]);
            check("mem_be", bus.mem_be, e[3:0]);
            if (e[68]) check("mem_wdata", bus.mem_wdata, e[35:4]);
          end
        end
        if (cur_lat >= 0 && mcnt == cur_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_rval;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 32'h0BAD0BAD;
        end
        mcnt++;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0BAD0BAD;
        if (mcnt != 0) last_run = mcnt;
        mcnt = 0;
      end
    end
  end

  // grant and response monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_gnt && bus.d_gnt) check("gnt_both", 1, 0);
      else if (bus.if_gnt || bus.d_gnt) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", 1, 0);
        else check("gnt_who", bus.d_gnt, gnt_q.pop_front());
      end
      if (bus.if_rvalid && bus.d_rvalid) check("rvalid_both", 1, 0);
      else if (bus.if_rvalid || bus.d_rvalid) begin
        if (rsp_q.size() == 0) check("rvalid_unexpected", 1, 0);
        else check("rsp", {bus.d_rvalid,
                           bus.d_rvalid ? bus.d_err : bus.if_err,
                           bus.d_rvalid ? bus.d_rdata : bus.if_rdata,
                           32'(cyc)}, rsp_q.pop_front());
      end
    end
  end

  // driver: raise a request, wait for its grant, push expectations, drop it
  task automatic drive(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input bit exp_rsp, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_be = be;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = is_d ? bus.d_gnt : bus.if_gnt;
    end
    if (!got) begin
      check(is_d ? "d_gnt_timeout" : "if_gnt_timeout", 0, 1);
    end else begin
      gcyc = cyc;
      mem_q.push_back({is_d ? we : 1'b0, addr, is_d ? wdata : 32'h0, is_d ? be : 4'hF});
      if (exp_rsp) begin
        if (ack_lat >= 0)
          rsp_q.push_back({is_d, 1'b0, (is_d && we) ? 32'h0 : mem_rval, 32'(gcyc + ack_lat + 2)});
        else
          rsp_q.push_back({is_d, 1'b1, 32'h0, 32'(gcyc + TO + 1)});
      end
    end
    @(posedge clk);
    #1;
    if (is_d) bus.d_req = 1'b0;
    else bus.if_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && !state_dbg && !bus.if_rvalid && !bus.d_rvalid) break;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int g1, g2;
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_be = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_d_gnt", bus.d_gnt, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}, 0);
    check("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
    check("rst_err", {bus.if_err, bus.d_err}, 0);
    check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    check("rst_state", state_dbg, 0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // IF read alone: ack on the third mem_req cycle -> rvalid at T+4
    ack_lat = 2; mem_rval = 32'hDEADBEEF;
    gnt_q.push_back(1'b0);
    drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, g1);
    drain();

    // simultaneous requests, ack on first mem_req cycle
    ack_lat = 0; mem_rval = 32'h5A5A0001;
`ifdef MEM_ARB_RR_EN
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    fork
      begin repeat (2) drive(1'b1, 1'b0, 32'h180, 32'h0, 4'hF, 1'b1, g1); end
      begin repeat (2) drive(1'b0, 1'b0, 32'h184, 32'h0, 4'h0, 1'b1, g2); end
    join
`else
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
    gnt_q.push_back(1'b0);
    fork
      begin repeat (4) drive(1'b1, 1'b0, 32'h180, 32'h0, 4'hF, 1'b1, g1); end
      begin drive(1'b0, 1'b0, 32'h184, 32'h0, 4'h0, 1'b1, g2); end
    join
    check("fixed_if_after_4d", g2, g1 + 2);
`endif
    drain();

    // D write: memory returns junk data, response must carry 0
    ack_lat = 0; mem_rval = 32'hFFFF0000;
    gnt_q.push_back(1'b1);
    drive(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011, 1'b1, g1);
    drain();

    // stray ack while idle is ignored
    @(posedge clk);
    #2 bus.mem_ack = 1'b1;
    @(negedge clk);
    check("stray_ack_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
    check("stray_ack_state", state_dbg, 0);
    check("stray_ack_mem_req", bus.mem_req, 0);
    drain();

    // timeout on D with IF pending
    ack_lat = -1; mem_rval = 32'h00C0FFEE;
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    fork
      drive(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1, g1);
      begin @(posedge clk); #1; drive(1'b0, 1'b0, 32'h304, 32'h0, 4'h0, 1'b1, g2); end
      begin @(negedge clk); repeat (3) @(posedge clk); ack_lat = 0; end
    join
    check("timeout_mem_req_cycles", last_run, TO);
    check("timeout_if_grant_cycle", g2, g1 + TO + 1);
    drain();

    // reset two cycles into BUSY aborts the transaction
    ack_lat = -1;
    gnt_q.push_back(1'b1);
    drive(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, g1);
    @(posedge clk);
    #1;
    rst = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h500;
    @(negedge clk);
    check("rst_mid_busy_still_req", bus.mem_req, 1);
    @(negedge clk);
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_if_gnt", bus.if_gnt, 0);
    check("rst_mid_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
    check("rst_mid_state", state_dbg, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; bus.if_req = 1'b0;
    ack_lat = 0; mem_rval = 32'hCAFE0001;
    gnt_q.push_back(1'b0);
    drive(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b1, g1);
    drain();

    // back-to-back IF reads with immediate ack
    ack_lat = 0; mem_rval = 32'h0000A11A;
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0);
    drive(1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 1'b1, g1);
    drive(1'b0, 1'b0, 32'h604, 32'h0, 4'h0, 1'b1, g2);
    check("b2b_grant_spacing", g2, g1 + 2);
    drain();
    repeat (3) @(posedge clk);

    check("gnt_q_empty", gnt_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
